// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Data wins by default; a wait counter forces a fetch grant after MAX_WAIT consecutive losses.
`default_nettype none

module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_stall,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IF   = 2'd1,
        S_D    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          fetch_due;
    logic          load_q;
    logic [DW-1:0] if_hold;
    logic [DW-1:0] d_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            load_q   <= 1'b0;
            if_hold  <= '0;
            d_hold   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (d_gnt)
                load_q <= ~d_wen;
            if (state == S_IF && !if_flush)
                if_hold <= mem_rdata;
            if (state == S_D && load_q)
                d_hold <= mem_rdata;
        end
    end

    always_comb begin
        fetch_due = if_req & (wait_cnt == WW'(MAX_WAIT));
        d_gnt     = d_req & ~fetch_due;
        if_gnt    = if_req & ~d_gnt;
        if_stall  = if_req & ~if_gnt;

        mem_addr  = d_gnt ? d_addr : if_addr;
        mem_wen   = d_gnt & d_wen;
        mem_wdata = d_wdata;

        state_nxt = S_IDLE;
        if (d_gnt)
            state_nxt = S_D;
        else if (if_gnt)
            state_nxt = S_IF;

        wait_nxt = wait_cnt;
        if (!if_req || if_gnt)
            wait_nxt = '0;
        else if (wait_cnt != WW'(MAX_WAIT))
            wait_nxt = wait_cnt + WW'(1);
    end

    // Responses come straight off the synchronous-read memory in the cycle after the grant;
    // the hold registers keep rdata stable between responses.
    always_comb begin
        if_valid = (state == S_IF) & ~if_flush;
        if_rdata = (state == S_IF) ? mem_rdata : if_hold;
        d_valid  = (state == S_D);
        d_rdata  = (state == S_D && load_q) ? mem_rdata : d_hold;
    end

endmodule

`default_nettype wire
